multi_pipe_engine: RTL and testbench

- Game-state engine for the pitch-controlled bird game: a parametrised successor to the single-pipe position logic.
- Scrolls NUM_PIPES obstacles with LFSR-randomised gaps and runs the IDLE/RUN/OVER game FSM.
- Counts score and keeps a best score.
- Sits between the game-tick clock divider and the collision/VGA pixel logic. All logic runs on the system clock; the game tick is an enable input.

---
 rtl/multi_pipe_engine.sv | 188 ++++++++++++++++++
 tb/tb_multi_pipe_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_pipe_engine.sv
// Game-state engine: scrolls NUM_PIPES obstacles with LFSR-drawn gaps, runs the
// IDLE/RUN/OVER game flow and keeps the current and best score.
//   state | meaning
//   IDLE  | pipes frozen at start positions, waiting for a start press
//   RUN   | pipes scroll on tick, crossings of bird_x add to the score
//   OVER  | collision seen, pipes frozen, a start press returns to IDLE
module multi_pipe_engine #(
  parameter int          NUM_PIPES    = 3,
  parameter int          PIPE_SPACING = 220,
  parameter int          SCREEN_W     = 640,
  parameter int          SPEED        = 4,
  parameter int          GAP_MIN      = 100,
  parameter int          GAP_RANGE    = 280,
  parameter int          GAP_HALF     = 60,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick,
  input  logic                     start_button,
  input  logic                     collided,
  input  logic [9:0]               bird_x,
  output logic [11*NUM_PIPES-1:0]  pipe_x,
  output logic [10*NUM_PIPES-1:0]  pipe_y_top,
  output logic [10*NUM_PIPES-1:0]  pipe_y_bot,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       best_score,
  output logic [1:0]               state,
  output logic                     game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10
  } state_t;

  localparam logic [15:0]        LFSR_MASK = 16'hB400;
  localparam logic [10:0]        SPEED_X   = 11'(SPEED);
  localparam logic [11:0]        SPEED_W   = 12'(SPEED);
  localparam logic [11:0]        WRAP_ADD  = 12'(NUM_PIPES * PIPE_SPACING);
  localparam logic [9:0]         CTR_RST   = 10'(GAP_MIN + GAP_RANGE / 2);
  localparam logic [9:0]         GAP_MIN_V = 10'(GAP_MIN);
  localparam logic [9:0]         GAP_RNG_V = 10'(GAP_RANGE);
  localparam logic [9:0]         GAP_HLF_V = 10'(GAP_HALF);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t              state_q, state_d;
  logic                start_q;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [10:0]         x_q   [NUM_PIPES];
  logic [10:0]         x_d   [NUM_PIPES];
  logic [9:0]          ctr_q [NUM_PIPES];
  logic [9:0]          ctr_d [NUM_PIPES];
  logic [9:0]          draw  [NUM_PIPES];
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  best_q, best_d;

  logic                start_edge;
  logic [10:0]         bird_ext;
  logic [10:0]         nx;
  logic [11:0]         nx_w;
  logic [2:0]          inc;
  logic [SCORE_W+2:0]  score_sum;

  function automatic logic [10:0] x_init(input int i);
    return 11'(SCREEN_W + i * PIPE_SPACING);
  endfunction

  // Pipe i looks at the LFSR rotated left by 3*i so pipes redrawn together differ.
  function automatic logic [15:0] rotl(input logic [15:0] v, input int k);
    logic [31:0] t;
    t = {v, v} << k;
    return t[31:16];
  endfunction

  function automatic logic [9:0] gap_draw(input logic [15:0] v, input int i);
    logic [15:0] rv;
    logic [9:0]  r;
    logic [9:0]  off;
    rv  = rotl(v, 3 * i);
    r   = {1'b0, rv[8:0]};
    off = (r > GAP_RNG_V) ? r - GAP_RNG_V : r;
    return GAP_MIN_V + off;
  endfunction

  assign start_edge = start_button & ~start_q;
  assign bird_ext   = {1'b0, bird_x};

  always_comb begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      draw[i] = gap_draw(lfsr_q, i);
    end
  end

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    score_d   = score_q;
    best_d    = best_q;
    nx        = '0;
    nx_w      = '0;
    inc       = '0;
    score_sum = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i]   = x_q[i];
      ctr_d[i] = ctr_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_RUN;
      end
      S_RUN: begin
        if (collided) begin
          state_d = S_OVER;
          best_d  = (score_q > best_q) ? score_q : best_q;
        end else if (tick) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (x_q[i] >= SPEED_X) begin
              nx = x_q[i] - SPEED_X;
            end else begin
              nx_w     = {1'b0, x_q[i]} - SPEED_W + WRAP_ADD;
              nx       = nx_w[10:0];
              ctr_d[i] = draw[i];
            end
            if (x_q[i] >= bird_ext && nx < bird_ext) inc = inc + 3'd1;
            x_d[i] = nx;
          end
          score_sum = {3'b000, score_q} + (SCORE_W + 3)'(inc);
          score_d   = (score_sum > (SCORE_W + 3)'(SCORE_MAX)) ? SCORE_MAX
                                                              : score_sum[SCORE_W-1:0];
        end
      end
      S_OVER: begin
        if (start_edge) begin
          state_d = S_IDLE;
          score_d = '0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            x_d[i]   = x_init(i);
            ctr_d[i] = CTR_RST;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      score_q <= '0;
      best_q  <= '0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_init(i);
        ctr_q[i] <= CTR_RST;
      end
    end else begin
      state_q <= state_d;
      start_q <= start_button;
      lfsr_q  <= lfsr_d;
      score_q <= score_d;
      best_q  <= best_d;
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i]   <= x_d[i];
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PIPES; g++) begin : g_pack
      assign pipe_x[11*g +: 11]     = x_q[g];
      assign pipe_y_top[10*g +: 10] = ctr_q[g] - GAP_HLF_V;
      assign pipe_y_bot[10*g +: 10] = ctr_q[g] + GAP_HLF_V;
    end
  endgenerate

  assign score      = score_q;
  assign best_score = best_q;
  assign state      = state_q;
  assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_multi_pipe_engine.sv
// Directed bench for multi_pipe_engine with default parameters: start/restart flow,
// scrolling, wrap and gap draw, scoring, collision, async reset and saturation.
module tb_multi_pipe_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        start_button;
  logic        collided;
  logic [9:0]  bird_x;
  logic [32:0] pipe_x;
  logic [29:0] pipe_y_top;
  logic [29:0] pipe_y_bot;
  logic [7:0]  score;
  logic [7:0]  best_score;
  logic [1:0]  state;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_lfsr;
  logic [15:0] snap;
  int          r_val;
  int          exp_ctr;

  multi_pipe_engine dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_button (start_button),
    .collided     (collided),
    .bird_x       (bird_x),
    .pipe_x       (pipe_x),
    .pipe_y_top   (pipe_y_top),
    .pipe_y_bot   (pipe_y_bot),
    .score        (score),
    .best_score   (best_score),
    .state        (state),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  // Reference Galois LFSR, free-running from the same reset as the engine.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px(input int i);
    return 32'(pipe_x[11*i +: 11]);
  endfunction

  function automatic logic [31:0] ytop(input int i);
    return 32'(pipe_y_top[10*i +: 10]);
  endfunction

  function automatic logic [31:0] ybot(input int i);
    return 32'(pipe_y_bot[10*i +: 10]);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    cyc(n);
    tick = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    tick         = 1'b0;
    start_button = 1'b0;
    collided     = 1'b0;
    bird_x       = 10'd100;
    cyc(2);
    reset = 1'b0;

    check("rst_state", 32'(state), 0);
    check("rst_game_over", 32'(game_over), 0);
    check("rst_score", 32'(score), 0);
    check("rst_best", 32'(best_score), 0);
    check("rst_x0", px(0), 640);
    check("rst_x1", px(1), 860);
    check("rst_x2", px(2), 1080);
    check("rst_ytop0", ytop(0), 180);
    check("rst_ybot0", ybot(0), 300);

    ticks(1);
    check("idle_tick_x0", px(0), 640);
    check("idle_tick_state", 32'(state), 0);

    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
    check("start_run", 32'(state), 1);

    ticks(10);
    check("run10_x0", px(0), 600);
    check("run10_x1", px(1), 820);
    check("run10_x2", px(2), 1040);
    check("run10_score", 32'(score), 0);

    cyc(1);
    check("no_tick_x0", px(0), 600);

    ticks(124);
    check("pre_cross_x0", px(0), 104);
    ticks(1);
    check("at_bird_x0", px(0), 100);
    check("at_bird_score", 32'(score), 0);
    ticks(1);
    check("cross_x0", px(0), 96);
    check("cross_score", 32'(score), 1);

    ticks(23);
    check("edge_x0_4", px(0), 4);
    ticks(1);
    check("edge_x0_0", px(0), 0);
    check("edge_score", 32'(score), 1);

    snap    = m_lfsr;
    r_val   = int'(snap[8:0]);
    exp_ctr = 100 + ((r_val > 280) ? r_val - 280 : r_val);
    ticks(1);
    check("wrap_x0", px(0), 656);
    check("wrap_ytop0", ytop(0), 32'(exp_ctr - 60));
    check("wrap_ybot0", ybot(0), 32'(exp_ctr + 60));
    check("wrap_ctr_range", 32'((ytop(0) + 60 >= 100) && (ytop(0) + 60 <= 380)), 1);
    check("wrap_x1", px(1), 216);
    check("wrap_ytop1", ytop(1), 180);

    collided = 1'b1;
    tick     = 1'b1;
    cyc(1);
    collided = 1'b0;
    tick     = 1'b0;
    check("coll_x0", px(0), 656);
    check("coll_x1", px(1), 216);
    check("coll_state", 32'(state), 2);
    check("coll_game_over", 32'(game_over), 1);
    check("coll_best", 32'(best_score), 1);
    check("coll_score", 32'(score), 1);

    ticks(1);
    check("over_tick_x0", px(0), 656);
    check("over_tick_state", 32'(state), 2);

    start_button = 1'b1;
    cyc(1);
    check("restart_state", 32'(state), 0);
    check("restart_x0", px(0), 640);
    check("restart_x1", px(1), 860);
    check("restart_x2", px(2), 1080);
    check("restart_ytop0", ytop(0), 180);
    check("restart_score", 32'(score), 0);
    check("restart_best", 32'(best_score), 1);
    check("restart_game_over", 32'(game_over), 0);
    cyc(3);
    check("held_start_idle", 32'(state), 0);
    start_button = 1'b0;
    cyc(1);
    check("released_idle", 32'(state), 0);
    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
    check("repress_run", 32'(state), 1);

    ticks(5);
    check("pre_reset_x0", px(0), 620);
    #2;
    reset = 1'b1;
    #1;
    check("async_state", 32'(state), 0);
    check("async_x0", px(0), 640);
    check("async_best", 32'(best_score), 0);
    check("async_score", 32'(score), 0);
    @(negedge clk);
    reset = 1'b0;

    start_button = 1'b1;
    cyc(1);
    start_button = 1'b0;
    check("sat_run", 32'(state), 1);
    tick = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (score == 8'd255) break;
      @(negedge clk);
    end
    check("sat_reach_255", 32'(score), 255);
    cyc(200);
    tick = 1'b0;
    check("sat_hold_255", 32'(score), 255);
    check("sat_best_before", 32'(best_score), 0);
    collided = 1'b1;
    cyc(1);
    collided = 1'b0;
    check("sat_best_after", 32'(best_score), 255);
    check("sat_over", 32'(state), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
